// File: rtl/timer_pkg.sv
// Shared definitions for the interval timers: default width and the
// run/idle state encoding.
package timer_pkg;

    localparam int TIMER_WIDTH = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/decrement_chain.sv
// Combinational ripple-borrow decrementer, the mirror of the increment carry chain.
// Input 0 would wrap to all-ones; callers never present it.
module decrement_chain #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] borrow;

    assign borrow[0] = 1'b1;

    // A borrow keeps rippling upward only through bits that are already 0.
    for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
        assign borrow[i] = ~value[i-1] & borrow[i-1];
    end

    assign next = value ^ borrow;

endmodule

// File: rtl/decrement_timer.sv
// Loadable down-counting timer with a one-cycle expiry pulse and optional auto-reload.
//   state | meaning
//   IDLE  | stopped; count holds (0 after expiry or reset), enable ignored
//   RUN   | count >= 1, decrements on each enabled cycle, expires on 1
module decrement_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             reload,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] COUNT_ZERO = '0;

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             reload_q, reload_d;
    logic             done_d;
    logic [WIDTH-1:0] count_dec;

    decrement_chain #(
        .WIDTH (WIDTH)
    ) u_decrement_chain (
        .value (count),
        .next  (count_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count    <= '0;
            period_q <= '0;
            reload_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            period_q <= period_d;
            reload_q <= reload_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count;
        period_d = period_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        // Load outranks both decrement and expiry, so a restart on the
        // terminal edge swallows that cycle's pulse.
        if (load) begin
            if (load_value != COUNT_ZERO) begin
                count_d  = load_value;
                period_d = load_value;
                reload_d = reload;
                state_d  = RUN;
            end else begin
                count_d = '0;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (enable) begin
                        if (count == COUNT_ONE) begin
                            done_d = 1'b1;
                            if (reload_q) begin
                                count_d = period_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_dec;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_decrement_timer.sv
// Self-checking bench for decrement_timer: directed scenarios plus a randomized
// run compared against an interval-level reference model.
module tb_decrement_timer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         reload = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    // reference model: remaining ticks, interval length, mode, running flag
    int m_left;
    int m_period;
    bit m_reload;
    bit m_run;
    bit m_done;

    decrement_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .reload     (reload),
        .enable     (enable),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load = 1'b0;
        enable = 1'b0;
        reload = 1'b0;
        load_value = '0;
        #3;
        reset = 1'b0;
        tick();
        m_left = 0; m_period = 0; m_reload = 0; m_run = 0; m_done = 0;
    endtask

    function automatic void model_step(bit ld, int lv, bit rl, bit en);
        m_done = 0;
        if (ld) begin
            m_run = (lv != 0);
            m_left = lv;
            if (lv != 0) begin
                m_period = lv;
                m_reload = rl;
            end
        end else if (m_run && en) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1;
                if (m_reload) m_left = m_period;
                else m_run = 0;
            end
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (count !== 0 || busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset_init: count=%0d busy=%0b done=%0b expected 0/0/0", count, busy, done);
        end
        reset = 1'b0;
        tick();
        load = 1'b1; load_value = 5'd20; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (count !== 5'd15 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_precount: count=%0d busy=%0b expected 15/1", count, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 0 || busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset_async: count=%0d busy=%0b done=%0b expected 0/0/0", count, busy, done);
        end
        #3;
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (done !== 0 || busy !== 0 || count !== 0) begin
                errors++;
                $display("FAIL reset_after: cycle %0d count=%0d busy=%0b done=%0b expected 0/0/0", i, count, busy, done);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_one_shot();
        load = 1'b1; load_value = 5'd3; reload = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 5'd3 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_load: count=%0d busy=%0b done=%0b expected 3/1/0", count, busy, done);
        end
        for (int k = 1; k <= 4; k++) begin
            int ec;
            bit ed, eb;
            tick();
            ec = (k <= 3) ? 3 - k : 0;
            ed = (k == 3);
            eb = (k < 3);
            checks++;
            if (count !== W'(ec) || done !== ed || busy !== eb) begin
                errors++;
                $display("FAIL one_shot: edge %0d count=%0d done=%0b busy=%0b expected %0d/%0b/%0b", k, count, done, busy, ec, ed, eb);
            end
        end
    endtask

    task automatic test_reload();
        load = 1'b1; load_value = 5'd4; reload = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0; reload = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            int ec;
            bit ed;
            tick();
            ec = (k % 4 == 0) ? 4 : 4 - (k % 4);
            ed = (k % 4 == 0);
            checks++;
            if (count !== W'(ec) || done !== ed || busy !== 1'b1) begin
                errors++;
                $display("FAIL reload: edge %0d count=%0d done=%0b busy=%0b expected %0d/%0b/1", k, count, done, busy, ec, ed);
            end
        end
        load = 1'b1; load_value = '0;
        tick();
        load = 1'b0;
    endtask

    task automatic test_pause();
        load = 1'b1; load_value = 5'd5; reload = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            int ec;
            bit ed;
            enable = (k % 2 == 0);
            tick();
            ec = (k >= 10) ? 0 : 5 - k / 2;
            ed = (k == 10);
            checks++;
            if (count !== W'(ec) || done !== ed) begin
                errors++;
                $display("FAIL pause: edge %0d count=%0d done=%0b expected %0d/%0b", k, count, done, ec, ed);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_reload_one();
        load = 1'b1; load_value = 5'd1; reload = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (count !== 5'd1 || done !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL reload_one: edge %0d count=%0d done=%0b busy=%0b expected 1/1/1", k, count, done, busy);
            end
        end
        load = 1'b1; load_value = '0; reload = 1'b0;
        tick();
        load = 1'b0;
    endtask

    task automatic test_load_zero();
        load = 1'b1; load_value = 5'd9; enable = 1'b1;
        tick();
        load_value = '0;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (count !== 0 || busy !== 0 || done !== 0) begin
                errors++;
                $display("FAIL load_zero: cycle %0d count=%0d busy=%0b done=%0b expected 0/0/0", k, count, busy, done);
            end
            tick();
        end
    endtask

    task automatic test_load_terminal();
        load = 1'b1; load_value = 5'd2; reload = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (count !== 5'd1) begin
            errors++;
            $display("FAIL load_term_pre: count=%0d expected 1", count);
        end
        load = 1'b1; load_value = 5'd7;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 5'd7 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_terminal: count=%0d busy=%0b done=%0b expected 7/1/0", count, busy, done);
        end
        load = 1'b1; load_value = '0;
        tick();
        load = 1'b0;
    endtask

    task automatic test_max();
        int seen;
        seen = 0;
        load = 1'b1; load_value = 5'd31; reload = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 40 && seen == 0; k++) begin
            tick();
            if (done === 1'b1) seen = k;
        end
        checks++;
        if (seen != 31 || count !== 0) begin
            errors++;
            $display("FAIL max_load: done after %0d edges count=%0d expected 31/0", seen, count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit ld, rl, en;
            int lv;
            ld = ($urandom_range(0, 15) == 0);
            lv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) lv = 31;
            rl = $urandom_range(0, 1);
            en = ($urandom_range(0, 3) != 0);
            load = ld; load_value = W'(lv); reload = rl; enable = en;
            model_step(ld, lv, rl, en);
            tick();
            checks++;
            if (count !== W'(m_left) || busy !== m_run || done !== m_done) begin
                errors++;
                $display("FAIL random: cycle %0d count=%0d busy=%0b done=%0b expected %0d/%0b/%0b", i, count, busy, done, m_left, m_run, m_done);
            end
        end
        load = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_reload();
        test_pause();
        test_reload_one();
        test_load_zero();
        test_load_terminal();
        test_max();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
